// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the two-requester APB arbiter.
// The register-map addresses describe the shared register-file slave.
package apb_arb_pkg;

  localparam int APB_ADDR_W_DEF = 32;
  localparam int APB_DATA_W_DEF = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SETUP  = ST_SETUP,
    ACCESS = ST_ACCESS
  } arb_state_e;

  typedef logic req_idx_t;

  localparam logic [31:0] REG_NUM_ADDR     = 32'h0;
  localparam logic [31:0] REG_DATE_ADDR    = 32'h4;
  localparam logic [31:0] REG_SURNAME_ADDR = 32'h8;
  localparam logic [31:0] REG_NAME_ADDR    = 32'hC;

  function automatic logic [1:0] req_onehot(input req_idx_t idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/apb_rr_pick.sv
// Two-way combinational round-robin picker: a lone eligible requester wins,
// on a tie the requester that was not served last wins.
module apb_rr_pick
  import apb_arb_pkg::*;
(
  input  logic [1:0] eligible,
  input  logic       last,
  output logic       valid,
  output logic       winner
);

  req_idx_t winner_idx;

  always_comb begin
    valid = |eligible;
    if (&eligible) begin
      winner_idx = ~last;
    end else begin
      winner_idx = eligible[1];
    end
  end

  assign winner = winner_idx;

endmodule

// File: rtl/apb_rr_arbiter.sv
// Two-requester round-robin APB arbiter/sequencer driving one slave port.
// Optional ACCESS timeout is enabled by defining APB_ARB_TIMEOUT_EN.
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W_DEF,
  parameter int DATA_W      = APB_DATA_W_DEF,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              REQ0,
  input  logic              REQ1,
  input  logic              WRITE0,
  input  logic              WRITE1,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] WDATA0,
  input  logic [DATA_W-1:0] WDATA1,
  output logic              GNT0,
  output logic              GNT1,
  output logic              DONE0,
  output logic              DONE1,
  output logic [DATA_W-1:0] RDATA,
  output logic              ERR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  arb_state_e        state_q, state_d;
  req_idx_t          last_q, last_d;
  req_idx_t          owner_q, owner_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              xfer_end;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
`endif

  logic [1:0]        req_in;
  logic [1:0]        write_in;
  logic [ADDR_W-1:0] addr_in  [2];
  logic [DATA_W-1:0] wdata_in [2];
  logic [1:0]        eligible;
  logic              pick_valid;
  logic              pick_winner;

  assign req_in      = {REQ1, REQ0};
  assign write_in    = {WRITE1, WRITE0};
  assign addr_in[0]  = ADDR0;
  assign addr_in[1]  = ADDR1;
  assign wdata_in[0] = WDATA0;
  assign wdata_in[1] = WDATA1;

  // A requester whose DONE is pulsing this cycle cannot be re-granted.
  for (genvar gi = 0; gi < 2; gi++) begin : g_elig
    assign eligible[gi] = req_in[gi] & ~done_q[gi];
  end

  apb_rr_pick u_pick (
    .eligible (eligible),
    .last     (last_q),
    .valid    (pick_valid),
    .winner   (pick_winner)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    gnt_d     = gnt_q;
    done_d    = 2'b00;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    rdata_d   = '0;
    xfer_end  = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d  = pick_winner;
          gnt_d    = req_onehot(pick_winner);
          pwrite_d = write_in[pick_winner];
          paddr_d  = addr_in[pick_winner];
          pwdata_d = wdata_in[pick_winner];
          psel_d   = 1'b1;
          state_d  = SETUP;
`ifdef APB_ARB_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end

      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end

      ACCESS: begin
        if (PREADY) begin
          xfer_end = 1'b1;
          rdata_d  = pwrite_q ? '0 : PRDATA;
        end
`ifdef APB_ARB_TIMEOUT_EN
        // The final stalled cycle is the TIMEOUT_CYC-th one; abort with RDATA=0.
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          xfer_end = 1'b1;
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
        if (xfer_end) begin
          done_d    = req_onehot(owner_q);
          gnt_d     = 2'b00;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          last_d    = owner_q;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d   = IDLE;
        gnt_d     = 2'b00;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      gnt_q     <= 2'b00;
      done_q    <= 2'b00;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      rdata_q   <= rdata_d;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  assign GNT0    = gnt_q[0];
  assign GNT1    = gnt_q[1];
  assign DONE0   = done_q[0];
  assign DONE1   = done_q[1];
  assign RDATA   = rdata_q;
  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
`ifdef APB_ARB_TIMEOUT_EN
  assign ERR     = err_q;
`else
  assign ERR     = 1'b0;
`endif

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Self-checking bench for apb_rr_arbiter: directed steps, then two randomized
// requester agents checked against a transaction-level model and register-file slave.
module tb_apb_rr_arbiter;
  import apb_arb_pkg::*;

  localparam int AW = APB_ADDR_W_DEF;
  localparam int DW = APB_DATA_W_DEF;
  localparam int TO = 16;

  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } txn_t;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          REQ0, REQ1, WRITE0, WRITE1;
  logic [AW-1:0] ADDR0, ADDR1;
  logic [DW-1:0] WDATA0, WDATA1;
  logic          GNT0, GNT1, DONE0, DONE1, ERR, PSEL, PENABLE, PWRITE;
  logic [DW-1:0] RDATA, PWDATA, PRDATA;
  logic [AW-1:0] PADDR;
  logic          PREADY;

  always #5 PCLK = ~PCLK;

  apb_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .REQ0(REQ0), .REQ1(REQ1), .WRITE0(WRITE0), .WRITE1(WRITE1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0), .DONE1(DONE1),
    .RDATA(RDATA), .ERR(ERR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] slv_mem [4];
  logic [31:0] exp_mem [4];
  int          wait_left = 0, waits_used = 0, wait_min = 0, wait_max = 0;
  bit          stuck = 0;
  logic [1:0]  g_rise, dec_req, dec_done;
  logic        last_served = 1'b1;
  txn_t        aq [2][$];
  int          idle_cnt [2];
  int          gnt_cyc [2];
  int          idle_max = 0;
  int          n_done = 0;
  int          glog[$];
  int          gcyc[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drive_req(int i, logic r, logic w, logic [31:0] a, logic [31:0] d);
    if (i == 0) begin
      REQ0 = r; WRITE0 = w; ADDR0 = a; WDATA0 = d;
    end else begin
      REQ1 = r; WRITE1 = w; ADDR1 = a; WDATA1 = d;
    end
  endtask

  task automatic drive_idle(int i);
    drive_req(i, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
  endtask

  // One clock: register-file slave with programmable wait states, plus event capture.
  task automatic tick();
    logic        commit, cw, g0p, g1p;
    logic [1:0]  idx;
    logic [31:0] cd;
    commit   = PSEL && PENABLE && PREADY;
    cw       = PWRITE;
    idx      = PADDR[3:2];
    cd       = PWDATA;
    dec_req  = {REQ1, REQ0};
    dec_done = {DONE1, DONE0};
    g0p      = GNT0;
    g1p      = GNT1;
    @(posedge PCLK);
    #1;
    cyc++;
    if (commit && cw) slv_mem[idx] = cd;
    g_rise = {GNT1 && !g1p, GNT0 && !g0p};
    if (PSEL && !PENABLE) begin
      wait_left  = stuck ? (1 << 30) : $urandom_range(wait_max, wait_min);
      waits_used = wait_left;
    end
    if (PSEL && PENABLE) begin
      PREADY = (wait_left == 0);
      if (wait_left > 0) wait_left--;
      PRDATA = slv_mem[PADDR[3:2]];
    end else begin
      PREADY = 1'($urandom_range(0, 1));
      PRDATA = $urandom;
    end
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_ctl"}, {24'h0, GNT0, GNT1, DONE0, DONE1, ERR, PSEL, PENABLE, PWRITE}, 32'h0);
    chk({tag, "_paddr"}, PADDR, 32'h0);
    chk({tag, "_pwdata"}, PWDATA, 32'h0);
    chk({tag, "_rdata"}, RDATA, 32'h0);
  endtask

  task automatic apply_reset(string tag);
    PRESET = 1'b1;
    drive_idle(0);
    drive_idle(1);
    tick();
    chk_all_zero(tag);
    PRESET = 1'b0;
    last_served = 1'b1;
  endtask

  // Single directed transfer from an otherwise idle requester pair.
  task automatic do_xfer(int i, logic w, logic [31:0] a, logic [31:0] d, int waits,
                         output logic [31:0] rd, output logic er, output int lat);
    logic seen_gnt, gi, di;
    wait_min = waits;
    wait_max = waits;
    drive_req(i, 1'b1, w, a, d);
    lat = 0; seen_gnt = 0; rd = '0; er = 1'b0; di = 1'b0;
    while (1) begin
      tick();
      lat++;
      gi = (i == 0) ? GNT0 : GNT1;
      di = (i == 0) ? DONE0 : DONE1;
      if (lat == 1) begin
        chk("setup_psel", 32'(PSEL), 32'd1);
        chk("setup_penable", 32'(PENABLE), 32'd0);
        chk("setup_gnt", 32'(gi), 32'd1);
      end
      if (lat == 2) chk("access_penable", 32'(PENABLE), 32'd1);
      if (gi) begin
        chk("bus_paddr", PADDR, a);
        chk("bus_pwdata", PWDATA, d);
        chk("bus_pwrite", 32'(PWRITE), 32'(w));
        if (!seen_gnt) begin
          seen_gnt = 1;
          drive_req(i, 1'b1, ~w, $urandom, $urandom);
        end
      end
      if (di) begin
        rd = RDATA;
        er = ERR;
        break;
      end
      if (lat >= 64) begin
        chk("xfer_done_seen", 32'(di), 32'd1);
        break;
      end
    end
    drive_idle(i);
    if (di) begin
      last_served = 1'(i);
      if (w && !er) exp_mem[a[3:2]] = d;
    end
    tick();
    chk("done_one_cycle", 32'((i == 0) ? DONE0 : DONE1), 32'd0);
  endtask

  task automatic present(int i);
    if (aq[i].size() > 0) drive_req(i, 1'b1, aq[i][0].w, aq[i][0].a, aq[i][0].d);
    else drive_idle(i);
  endtask

  // Transaction-level reference: winner choice, bus contents, data and latency.
  task automatic agents_step();
    logic [1:0]  elig;
    logic        exp_w, di, ri;
    txn_t        h;
    logic [31:0] exp_rd;
    for (int i = 0; i < 2; i++) begin
      if (g_rise[i]) begin
        elig  = dec_req & ~dec_done;
        exp_w = (elig == 2'b11) ? ~last_served : elig[1];
        chk("grant_winner", 32'(i), 32'(exp_w));
        if (aq[i].size() == 0) begin
          chk("grant_requested", 32'(aq[i].size()), 32'd1);
        end else begin
          h = aq[i][0];
          chk("grant_paddr", PADDR, h.a);
          chk("grant_pwdata", PWDATA, h.d);
          chk("grant_pwrite", 32'(PWRITE), 32'(h.w));
        end
        gnt_cyc[i] = cyc;
        glog.push_back(i);
        gcyc.push_back(cyc);
      end
    end
    for (int i = 0; i < 2; i++) begin
      di = (i == 0) ? DONE0 : DONE1;
      ri = (i == 0) ? REQ0 : REQ1;
      if (di) begin
        if (aq[i].size() == 0) begin
          chk("done_requested", 32'(aq[i].size()), 32'd1);
        end else begin
          h = aq[i].pop_front();
          exp_rd = h.w ? 32'h0 : exp_mem[h.a[3:2]];
          chk("done_rdata", RDATA, exp_rd);
          chk("done_err", 32'(ERR), 32'd0);
          chk("done_latency", 32'(cyc - gnt_cyc[i]), 32'(2 + waits_used));
          if (h.w) exp_mem[h.a[3:2]] = h.d;
        end
        last_served = 1'(i);
        n_done++;
        if (aq[i].size() > 0 && (idle_max == 0 || $urandom_range(0, 1) == 1)) begin
          present(i);
        end else begin
          drive_idle(i);
          idle_cnt[i] = (idle_max == 0) ? 0 : $urandom_range(1, idle_max);
        end
      end else if (!ri) begin
        if (idle_cnt[i] > 0) idle_cnt[i]--;
        else present(i);
      end
    end
  endtask

  task automatic run_agents(int total, int budget);
    int spent;
    n_done = 0;
    spent  = 0;
    glog.delete();
    gcyc.delete();
    for (int i = 0; i < 2; i++) begin
      idle_cnt[i] = 0;
      present(i);
    end
    while (n_done < total && spent < budget) begin
      tick();
      spent++;
      agents_step();
    end
    if (n_done < total) chk("agents_completed", 32'(n_done), 32'(total));
    drive_idle(0);
    drive_idle(1);
    tick();
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    t.w = 1'($urandom_range(0, 1));
    t.a = 32'($urandom_range(0, 3)) << 2;
    t.d = $urandom;
    return t;
  endfunction

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;

    PREADY = 1'b0;
    PRDATA = '0;
    for (int k = 0; k < 4; k++) begin
      slv_mem[k] = $urandom;
      exp_mem[k] = slv_mem[k];
    end
    apply_reset("reset");
    tick();

    // Zero-wait write from requester 0.
    do_xfer(0, 1'b1, REG_NUM_ADDR, 32'h3135, 0, rd, er, lat);
    chk("wr0_latency", 32'(lat), 32'd3);
    chk("wr0_err", 32'(er), 32'd0);
    chk("wr0_rdata", rd, 32'h0);

    // Requester 1 writes then reads back the name register.
    do_xfer(1, 1'b1, REG_NAME_ADDR, 32'h44415259, 0, rd, er, lat);
    chk("wr1_latency", 32'(lat), 32'd3);
    chk("idle_hold_paddr", PADDR, REG_NAME_ADDR);
    chk("idle_hold_pwdata", PWDATA, 32'h44415259);
    chk("idle_psel", 32'(PSEL), 32'd0);
    do_xfer(1, 1'b0, REG_NAME_ADDR, $urandom, 0, rd, er, lat);
    chk("rd1_rdata", rd, 32'h44415259);
    chk("rd1_latency", 32'(lat), 32'd3);

    // Three PREADY wait cycles stretch ACCESS.
    do_xfer(0, 1'b0, REG_NUM_ADDR, $urandom, 3, rd, er, lat);
    chk("wait3_latency", 32'(lat), 32'd6);
    chk("wait3_rdata", rd, 32'h3135);

    // Both requesters held from reset: order 0,1,0,1, three cycles apart.
    apply_reset("reset_rr");
    wait_min = 0; wait_max = 0; idle_max = 0;
    for (int i = 0; i < 2; i++) begin
      aq[i].delete();
      repeat (2) aq[i].push_back(rand_txn());
    end
    run_agents(4, 100);
    if (glog.size() < 4) begin
      chk("rr_grants", 32'(glog.size()), 32'd4);
    end else begin
      for (int k = 0; k < 4; k++) begin
        chk("rr_order", 32'(glog[k]), 32'(k % 2));
        if (k > 0) chk("rr_spacing", 32'(gcyc[k] - gcyc[k-1]), 32'd3);
      end
    end

    // Reset during ACCESS abandons the transfer silently.
    wait_min = 5; wait_max = 5;
    drive_req(0, 1'b1, 1'b1, REG_DATE_ADDR, 32'h20240101);
    repeat (3) tick();
    chk("pre_rst_penable", 32'(PENABLE), 32'd1);
    apply_reset("rst_mid");
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_no_done", 32'({DONE1, DONE0}), 32'd0);
    end
    do_xfer(0, 1'b0, REG_DATE_ADDR, $urandom, 0, rd, er, lat);
    chk("post_rst_latency", 32'(lat), 32'd3);
    chk("post_rst_rdata", rd, exp_mem[1]);

`ifdef APB_ARB_TIMEOUT_EN
    stuck = 1;
    do_xfer(1, 1'b0, REG_SURNAME_ADDR, $urandom, 0, rd, er, lat);
    chk("to_err", 32'(er), 32'd1);
    chk("to_rdata", rd, 32'h0);
    chk("to_latency", 32'(lat), 32'(2 + TO));
    stuck = 0;
    do_xfer(1, 1'b0, REG_SURNAME_ADDR, $urandom, 0, rd, er, lat);
    chk("after_to_err", 32'(er), 32'd0);
    chk("after_to_rdata", rd, exp_mem[2]);
    chk("after_to_latency", 32'(lat), 32'd3);
`endif

    // Randomized traffic from both requesters with random gaps and waits.
    wait_min = 0; wait_max = 3; idle_max = 2;
    for (int i = 0; i < 2; i++) begin
      aq[i].delete();
      repeat (30) aq[i].push_back(rand_txn());
    end
    run_agents(60, 2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_rr_arbiter.md
# apb_rr_arbiter

Two-requester APB bus arbiter and sequencer. Shares one APB slave port (the register-file slave holding number-in-group, date, surname and name at addresses 0x0/0x4/0x8/0xC) between two independent requesters. Performs round-robin selection, drives the full SETUP/ACCESS protocol, and returns read data and completion status to the winner. Sits between the requesters and the APB slave, in place of a single-master APB front end.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYC, 16, ACCESS cycles without PREADY before abort (used only with the timeout feature)

Ports:
- PCLK  in  1  clock; all logic on rising edge
- PRESET  in  1  reset, synchronous, active-high
- REQ0, REQ1  in  1  transfer request, level
- WRITE0, WRITE1  in  1  1 = write, 0 = read
- ADDR0, ADDR1  in  ADDR_W  target address
- WDATA0, WDATA1  in  DATA_W  write data
- GNT0, GNT1  out  1  requester owns the bus (SETUP + ACCESS)
- DONE0, DONE1  out  1  one-cycle completion pulse
- RDATA  out  DATA_W  read data; valid while DONEx is high
- ERR  out  1  completion was a timeout; valid with DONEx
- PSEL, PENABLE, PWRITE  out  1  APB control
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB ready

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- **IDLE**
  - If neither REQx is eligible, stay in IDLE.
  - A requester is eligible when its REQx is high and its DONEx is low in the same cycle. A requester cannot be re-granted in the cycle its DONE pulses.
  - With one eligible requester, it wins.
  - With both eligible, the requester not served last wins (round-robin pointer `last`).
  - On a win: latch ADDRx, WDATAx and WRITEx into PADDR/PWDATA/PWRITE, assert GNTx, and go to SETUP.
- **SETUP**: PSEL=1, PENABLE=0. Go to ACCESS unconditionally.
- **ACCESS**: PSEL=1, PENABLE=1.
  - When PREADY=1: capture PRDATA into RDATA on reads; writes leave RDATA=0.
  - Pulse DONEx for one cycle with ERR=0, clear GNTx and PSEL/PENABLE, set `last` to the winner, and go to IDLE.
- Request inputs are sampled only at grant. Changing them afterwards has no effect on the in-flight transfer.
- Dropping REQx before grant withdraws the request.
- The requester must drop REQx on seeing DONEx, or a new transfer starts.
- PADDR/PWDATA/PWRITE hold their last values in IDLE.

## Timing
- Reset value of all outputs is 0, state is IDLE, and `last` = 1 (requester 0 wins the first tie).
- PRESET mid-transfer: abandons the transfer at the next edge. No DONE is issued and the bus is released.
- All outputs are registered.
- Latency with zero-wait slave:
  - REQ seen in cycle n; SETUP in n+1; ACCESS in n+2; DONE in n+3.
  - The next grant can be taken in n+3, giving 3 cycles per transfer back-to-back.
- Each PREADY wait cycle adds one cycle to ACCESS.
- Alternating service under continuous double request: 0, 1, 0, 1…

## Configuration
- Macro: APB_ARB_TIMEOUT_EN.
- **Defined**
  - A counter counts ACCESS cycles with PREADY=0.
  - Reaching TIMEOUT_CYC forces completion: DONEx=1, ERR=1, RDATA=0. Then PSEL and PENABLE drop and the FSM returns to IDLE.
  - The counter clears on every entry to SETUP.
- **Undefined**: no counter; ACCESS waits indefinitely and ERR is tied 0.

## Structure
- Package apb_arb_pkg:
  - state enum typedef (IDLE/SETUP/ACCESS)
  - default ADDR_W/DATA_W constants
  - requester-index typedef
  - register-map address constants 0x0/0x4/0x8/0xC
- Sub-module apb_rr_pick: 2-way combinational round-robin picker.
  - Inputs: eligible[1:0], last.
  - Outputs: valid, winner.

## Test plan
- REQ0 write 0x3135 to 0x0, PREADY tied 1 → PSEL in n+1, PENABLE in n+2, DONE0 in n+3, ERR=0.
- REQ1 read 0xC after writing 0x44415259 → DONE1 with RDATA=0x44415259.
- REQ0 and REQ1 held together for 4 transfers from reset → grant order 0, 1, 0, 1, each 3 cycles apart.
- Slave holds PREADY=0 for 3 ACCESS cycles → DONE delayed 3 cycles, PADDR/PWDATA stable throughout.
- With APB_ARB_TIMEOUT_EN, PREADY stuck 0 → DONE with ERR=1 and RDATA=0 after 16 ACCESS cycles; the next request proceeds normally.
- PRESET asserted during ACCESS → next cycle all outputs 0, no DONE; a following REQ0 completes in 3 cycles.
